// File: rtl/seq_detect_pkg.sv
// seq_detect_pkg: shared defaults, width helper and shadow-config type for seq_detect_prog
package seq_detect_pkg;
  localparam int MAX_LEN_DEF = 8;
  localparam int CNT_W_DEF = 8;
  localparam int CFG_PAT_W = 64;
  localparam int CFG_LEN_W = 7;
  function automatic int len_w(input int max_len);
    return $clog2(max_len + 1);
  endfunction
  // Sized for the largest supported MAX_LEN; unused upper bits load as zero
  typedef struct packed {
    logic [CFG_PAT_W-1:0] pattern;
    logic [CFG_LEN_W-1:0] len;
    logic                 overlap;
  } cfg_t;
endpackage

// File: rtl/sat_counter.sv
// sat_counter: W-bit up counter with synchronous clear that sticks at all-ones
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] count
);
  logic [W-1:0] r_count;
  always_ff @(posedge clk or negedge reset)
    if (!reset) r_count <= '0;
    else if (clr) r_count <= '0;
    else if (inc && r_count != '1) r_count <= r_count + 1'b1;
  assign count = r_count;
endmodule

// File: rtl/seq_detect_prog.sv
// seq_detect_prog: runtime-programmable serial pattern detector with saturating match count
module seq_detect_prog
  import seq_detect_pkg::*;
#(
  parameter int MAX_LEN = MAX_LEN_DEF,
  parameter int CNT_W = CNT_W_DEF,
  localparam int LEN_W = len_w(MAX_LEN)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               inp_bit,
  input  logic               inp_valid,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_overlap,
  input  logic               cfg_load,
  input  logic               clr_count,
  output logic               seq_seen,
  output logic [CNT_W-1:0]   match_count
);
  cfg_t               r_cfg;
  logic [MAX_LEN-1:0] r_hist;
  logic [LEN_W-1:0]   r_fill;
  logic               r_seen;
  logic [MAX_LEN-1:0] w_hist_next;
  logic [LEN_W-1:0]   w_fill_next;
  logic [LEN_W-1:0]   w_len_clamp;
  logic [CFG_PAT_W-1:0] w_mask;
  logic               w_len_ok;
  logic               w_hit;
  logic               w_match;

  assign w_hist_next = {r_hist[MAX_LEN-2:0], inp_bit};
  assign w_fill_next = (r_fill == LEN_W'(MAX_LEN)) ? r_fill : r_fill + 1'b1;
  assign w_len_clamp = (cfg_len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : cfg_len;
  // Only the low len bits of the shifted history take part in the compare
  assign w_mask = (CFG_PAT_W'(1) << r_cfg.len) - CFG_PAT_W'(1);
  assign w_len_ok = (r_cfg.len != '0) && (CFG_LEN_W'(w_fill_next) >= r_cfg.len);
  assign w_hit = ((CFG_PAT_W'(w_hist_next) ^ r_cfg.pattern) & w_mask) == '0;
  assign w_match = inp_valid & ~cfg_load & w_len_ok & w_hit;

  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      r_cfg  <= '0;
      r_hist <= '0;
      r_fill <= '0;
      r_seen <= 1'b0;
    end else if (cfg_load) begin
      r_cfg  <= '{pattern: CFG_PAT_W'(cfg_pattern), len: CFG_LEN_W'(w_len_clamp), overlap: cfg_overlap};
      r_hist <= '0;
      r_fill <= '0;
      r_seen <= 1'b0;
    end else if (inp_valid) begin
      r_hist <= w_hist_next;
      r_fill <= (w_match && !r_cfg.overlap) ? '0 : w_fill_next;
      r_seen <= w_match;
    end else begin
      r_seen <= 1'b0;
    end

  sat_counter #(.W(CNT_W)) u_cnt (
    .clk  (clk),
    .reset(reset),
    .inc  (w_match),
    .clr  (clr_count),
    .count(match_count)
  );

  assign seq_seen = r_seen;
endmodule

// File: tb/tb_seq_detect_prog.sv
// tb_seq_detect_prog: scoreboarded random and directed checks against a queue-based reference model
module tb_seq_detect_prog;
  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       inp_bit = 1'b0;
  logic       inp_valid = 1'b0;
  logic [7:0] cfg_pattern = '0;
  logic [3:0] cfg_len = '0;
  logic       cfg_overlap = 1'b0;
  logic       cfg_load = 1'b0;
  logic       clr_count = 1'b0;
  logic       seen8, seen2;
  logic [7:0] cnt8;
  logic [1:0] cnt2;

  typedef struct {
    logic       s;
    logic [7:0] c8;
    logic [1:0] c2;
  } exp_t;

  exp_t sb[$];
  bit   mq[$];
  logic [7:0] m_pat;
  int   m_len, m_c8, m_c2;
  bit   m_ov;
  int   n_cmp = 0, n_bad = 0;

  always #5 clk = ~clk;

  seq_detect_prog #(.MAX_LEN(8), .CNT_W(8)) u_dut8 (
    .clk(clk), .reset(reset), .inp_bit(inp_bit), .inp_valid(inp_valid),
    .cfg_pattern(cfg_pattern), .cfg_len(cfg_len), .cfg_overlap(cfg_overlap),
    .cfg_load(cfg_load), .clr_count(clr_count), .seq_seen(seen8), .match_count(cnt8)
  );

  seq_detect_prog #(.MAX_LEN(8), .CNT_W(2)) u_dut2 (
    .clk(clk), .reset(reset), .inp_bit(inp_bit), .inp_valid(inp_valid),
    .cfg_pattern(cfg_pattern), .cfg_len(cfg_len), .cfg_overlap(cfg_overlap),
    .cfg_load(cfg_load), .clr_count(clr_count), .seq_seen(seen2), .match_count(cnt2)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: remember the valid bits seen since the last flush, match on the newest len of them
  task automatic step(input logic b, input logic v, input logic ld, input logic clr);
    exp_t e;
    bit hit;
    @(negedge clk);
    inp_bit = b; inp_valid = v; cfg_load = ld; clr_count = clr;
    hit = 0;
    if (ld) begin
      m_pat = cfg_pattern;
      m_len = (cfg_len > 8) ? 8 : int'(cfg_len);
      m_ov  = cfg_overlap;
      mq.delete();
    end else if (v) begin
      mq.push_back(b);
      if (mq.size() > 8) void'(mq.pop_front());
      if (m_len != 0 && mq.size() >= m_len) begin
        hit = 1;
        for (int i = 0; i < m_len; i++)
          if (mq[mq.size()-1-i] != m_pat[i]) hit = 0;
      end
      if (hit && !m_ov) mq.delete();
    end
    if (clr) begin
      m_c8 = 0;
      m_c2 = 0;
    end else if (hit) begin
      if (m_c8 < 255) m_c8++;
      if (m_c2 < 3) m_c2++;
    end
    e.s = hit; e.c8 = 8'(m_c8); e.c2 = 2'(m_c2);
    sb.push_back(e);
  endtask

  task automatic bits(input logic [15:0] s, input int n);
    for (int i = n - 1; i >= 0; i--) step(s[i], 1'b1, 1'b0, 1'b0);
  endtask

  task automatic load(input logic [7:0] p, input logic [3:0] l, input logic ov);
    cfg_pattern = p; cfg_len = l; cfg_overlap = ov;
    step(1'b0, 1'b0, 1'b1, 1'b1);
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_reset(input string nm);
    @(negedge clk);
    inp_valid = 1'b0; cfg_load = 1'b0; clr_count = 1'b0;
    #2 reset = 1'b0;
    #1;
    chk({nm, "_seen8"}, 32'(seen8), 0);
    chk({nm, "_seen2"}, 32'(seen2), 0);
    chk({nm, "_cnt8"}, 32'(cnt8), 0);
    chk({nm, "_cnt2"}, 32'(cnt2), 0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    sb.delete(); mq.delete();
    m_pat = '0; m_len = 0; m_ov = 0; m_c8 = 0; m_c2 = 0;
  endtask

  always @(posedge clk) begin
    exp_t e;
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("seen8", 32'(seen8), 32'(e.s));
      chk("seen2", 32'(seen2), 32'(e.s));
      chk("cnt8", 32'(cnt8), 32'(e.c8));
      chk("cnt2", 32'(cnt2), 32'(e.c2));
    end
  end

  initial begin
    do_reset("rst0");
    load(8'b1011, 4'd4, 1'b1);
    bits(16'b1011011, 7);
    idle();
    chk("ovl_count", 32'(cnt8), 2);
    load(8'b1011, 4'd4, 1'b0);
    bits(16'b1011011, 7);
    idle();
    chk("novl_count", 32'(cnt8), 1);
    load(8'b101, 4'd3, 1'b1);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'($urandom), 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    step(1'($urandom), 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    idle();
    chk("gap_count", 32'(cnt8), 1);
    load(8'b1, 4'd1, 1'b1);
    bits(16'b11111, 5);
    idle();
    chk("sat2_count", 32'(cnt2), 3);
    chk("five_count", 32'(cnt8), 5);
    step(1'b1, 1'b1, 1'b0, 1'b1);
    idle();
    load(8'b1011, 4'd4, 1'b1);
    bits(16'b101, 3);
    step(1'b1, 1'b1, 1'b1, 1'b0);
    bits(16'b011, 3);
    bits(16'b1011, 4);
    idle();
    chk("reload_count", 32'(cnt8), 1);
    load(8'b1011, 4'd4, 1'b1);
    bits(16'b1011101, 7);
    do_reset("rst_mid");
    for (int i = 0; i < 20; i++) step(1'($urandom), 1'b1, 1'b0, 1'b0);
    load(8'($urandom), 4'd0, 1'($urandom));
    for (int i = 0; i < 40; i++) step(1'($urandom), 1'b1, 1'b0, 1'b0);
    idle();
    chk("len0_count", 32'(cnt8), 0);
    load(8'hA5, 4'd1, 1'b1);
    for (int i = 0; i < 260; i++) step(1'b1, 1'b1, 1'b0, 1'b0);
    idle();
    chk("sat8_count", 32'(cnt8), 255);
    load(8'($urandom), 4'($urandom_range(1, 4)), 1'($urandom));
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 39) == 0) begin
        cfg_pattern = 8'($urandom); cfg_len = 4'($urandom); cfg_overlap = 1'($urandom);
        step(1'($urandom), 1'($urandom), 1'b1, 1'($urandom_range(0, 3) == 0));
      end else begin
        step(1'($urandom), 1'($urandom_range(0, 3) != 0), 1'b0, 1'($urandom_range(0, 49) == 0));
      end
    end
    idle();
    repeat (3) @(negedge clk);
    chk("sb_drained", 32'(sb.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
